// File: rtl/logic_pod_pkg.sv
// Shared types for the logic pod capture path.
// Holds the capture state enum and the 16-bit {n, p} sample word.
// Imported by logic_pod_capture_ctrl and logic_pod_trigger_match.
package logic_pod_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FILL      = 3'd1,
    ST_WAIT_TRIG = 3'd2,
    ST_POST      = 3'd3,
    ST_DONE      = 3'd4
  } cap_state_t;

  typedef struct packed {
    logic [7:0] n;
    logic [7:0] p;
  } sample_t;

endpackage

// File: rtl/logic_pod_trigger_match.sv
// Registers the incoming pod sample and its trigger-match flag in the same cycle,
// so the match always describes the sample it travels with.
// Ports: clk/rst_n; p_in/n_in sample; force_trig; mask/value compare config;
//        sample = registered {n, p}; match = registered trigger condition.
module logic_pod_trigger_match (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  p_in,
  input  logic [7:0]  n_in,
  input  logic        force_trig,
  input  logic [7:0]  mask,
  input  logic [7:0]  value,
  output logic [15:0] sample,
  output logic        match
);

  import logic_pod_pkg::*;

  sample_t smp_q;
  logic    match_q;
  logic    match_d;

  // An all-zero mask never matches; only force_trig can fire then.
  assign match_d = force_trig | ((|mask) & (((p_in ^ value) & mask) == 8'h00));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_q   <= '0;
      match_q <= 1'b0;
    end else begin
      smp_q.n <= n_in;
      smp_q.p <= p_in;
      match_q <= match_d;
    end
  end

  assign sample = smp_q;
  assign match  = match_q;

endmodule

// File: rtl/logic_pod_capture_ctrl.sv
// Logic pod capture controller: streams registered {n, p} samples into a circular
// capture RAM, honours a trigger only after pretrig_depth samples, then stores
// posttrig_depth more samples and stops in DONE holding the trigger address.
// Ports: clk_312p5mhz/rst_n; p_in/n_in samples; arm/abort pulses; force_trig level;
//        trig_mask/trig_value/pretrig_depth/posttrig_depth config (latched on arm);
//        mem_wr_en/mem_wr_addr/mem_wr_data RAM write port; trig_addr/trig_timestamp;
//        busy (FILL, WAIT_TRIG, POST); done (DONE).
// Build option: define LOGIC_POD_TRIG_TIMESTAMP_EN to add a free-running timestamp
// counter; otherwise trig_timestamp is tied to zero.
module logic_pod_capture_ctrl #(
  parameter int ADDR_BITS = 12,
  parameter int TS_BITS   = 32
) (
  input  logic                 clk_312p5mhz,
  input  logic                 rst_n,
  input  logic [7:0]           p_in,
  input  logic [7:0]           n_in,
  input  logic                 arm,
  input  logic                 abort,
  input  logic                 force_trig,
  input  logic [7:0]           trig_mask,
  input  logic [7:0]           trig_value,
  input  logic [ADDR_BITS-1:0] pretrig_depth,
  input  logic [ADDR_BITS-1:0] posttrig_depth,
  output logic                 mem_wr_en,
  output logic [ADDR_BITS-1:0] mem_wr_addr,
  output logic [15:0]          mem_wr_data,
  output logic [ADDR_BITS-1:0] trig_addr,
  output logic [TS_BITS-1:0]   trig_timestamp,
  output logic                 busy,
  output logic                 done
);

  import logic_pod_pkg::*;

  cap_state_t           state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q;
  logic [ADDR_BITS-1:0] cnt_q;
  logic [ADDR_BITS-1:0] pre_q, post_q;
  logic [7:0]           mask_q, value_q;
  logic [ADDR_BITS-1:0] trig_addr_q;
  logic                 arm_ok;
  logic                 wr;
  logic                 trig_hit;
  logic [7:0]           mask_sel, value_sel;
  logic                 match_q;
  sample_t              smp_q;

  // arm is only accepted when no capture is running, and abort always wins.
  assign arm_ok = arm & ~abort & ((state_q == ST_IDLE) | (state_q == ST_DONE));

  // The sample presented in the arm cycle is the first one written, so it must be
  // compared against the config being latched now, not the stale one.
  assign mask_sel  = arm_ok ? trig_mask  : mask_q;
  assign value_sel = arm_ok ? trig_value : value_q;

  logic_pod_trigger_match u_match (
    .clk        (clk_312p5mhz),
    .rst_n      (rst_n),
    .p_in       (p_in),
    .n_in       (n_in),
    .force_trig (force_trig),
    .mask       (mask_sel),
    .value      (value_sel),
    .sample     (smp_q),
    .match      (match_q)
  );

  always_comb begin
    state_d  = state_q;
    wr       = 1'b0;
    trig_hit = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (arm_ok) state_d = (pretrig_depth == '0) ? ST_WAIT_TRIG : ST_FILL;
      end
      ST_FILL: begin
        wr = 1'b1;
        // FILL is only entered with pre_q >= 1, so cnt_q + 1 cannot wrap.
        if ((cnt_q + ADDR_BITS'(1)) == pre_q) state_d = ST_WAIT_TRIG;
      end
      ST_WAIT_TRIG: begin
        wr = 1'b1;
        if (match_q) begin
          trig_hit = 1'b1;
          state_d  = (post_q == '0) ? ST_DONE : ST_POST;
        end
      end
      ST_POST: begin
        wr = 1'b1;
        if ((cnt_q + ADDR_BITS'(1)) == post_q) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d  = ST_IDLE;
      trig_hit = 1'b0;
    end
  end

  always_ff @(posedge clk_312p5mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      pre_q       <= '0;
      post_q      <= '0;
      mask_q      <= '0;
      value_q     <= '0;
      trig_addr_q <= '0;
    end else begin
      state_q <= state_d;
      if (arm_ok) begin
        addr_q      <= '0;
        cnt_q       <= '0;
        pre_q       <= pretrig_depth;
        post_q      <= posttrig_depth;
        mask_q      <= trig_mask;
        value_q     <= trig_value;
        trig_addr_q <= '0;
      end else begin
        if (wr) begin
          addr_q <= addr_q + ADDR_BITS'(1);
          // The counter restarts while waiting so POST counts its own writes.
          cnt_q  <= (state_q == ST_WAIT_TRIG) ? '0 : cnt_q + ADDR_BITS'(1);
        end
        if (trig_hit) trig_addr_q <= addr_q;
      end
    end
  end

`ifdef LOGIC_POD_TRIG_TIMESTAMP_EN
  logic [TS_BITS-1:0] ts_cnt_q;
  logic [TS_BITS-1:0] ts_q;

  // Free-running; the value latched is the count in the cycle the trigger
  // sample is written to the RAM.
  always_ff @(posedge clk_312p5mhz or negedge rst_n) begin
    if (!rst_n) begin
      ts_cnt_q <= '0;
      ts_q     <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + TS_BITS'(1);
      if (arm_ok)        ts_q <= '0;
      else if (trig_hit) ts_q <= ts_cnt_q;
    end
  end

  assign trig_timestamp = ts_q;
`else
  assign trig_timestamp = '0;
`endif

  assign mem_wr_en   = wr;
  assign mem_wr_addr = addr_q;
  assign mem_wr_data = smp_q;
  assign trig_addr   = trig_addr_q;
  assign busy        = wr;
  assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_logic_pod_capture_ctrl.sv
// Bench for logic_pod_capture_ctrl: two instances (12-bit and 4-bit address) share
// the same stimulus; every capture is rebuilt from the recorded input samples.
// Ports: none (top-level bench).
module tb_logic_pod_capture_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  p_in, n_in, trig_mask, trig_value;
  logic        arm, abort, force_trig;
  logic [11:0] pre_in, post_in;

  logic        b_wr_en, b_busy, b_done;
  logic [11:0] b_wr_addr, b_trig_addr;
  logic [15:0] b_data;
  logic [31:0] b_ts;

  logic        s_wr_en, s_busy, s_done;
  logic [3:0]  s_wr_addr, s_trig_addr;
  logic [15:0] s_data;
  logic [31:0] s_ts;

  logic [31:0] ts_model;
  int          n_cmp = 0;
  int          n_bad = 0;

  logic [7:0]  sp[$];
  logic [7:0]  sn[$];
  bit          sf[$];
  int unsigned b_aq[$];
  logic [15:0] b_dq[$];
  logic [31:0] b_tq[$];
  int unsigned s_aq[$];
  logic [15:0] s_dq[$];
  logic [31:0] s_tq[$];

  always #5 clk = ~clk;

  logic_pod_capture_ctrl #(.ADDR_BITS(12), .TS_BITS(32)) u_dut (
    .clk_312p5mhz(clk), .rst_n(rst_n), .p_in(p_in), .n_in(n_in), .arm(arm), .abort(abort),
    .force_trig(force_trig), .trig_mask(trig_mask), .trig_value(trig_value),
    .pretrig_depth(pre_in), .posttrig_depth(post_in), .mem_wr_en(b_wr_en),
    .mem_wr_addr(b_wr_addr), .mem_wr_data(b_data), .trig_addr(b_trig_addr),
    .trig_timestamp(b_ts), .busy(b_busy), .done(b_done)
  );

  logic_pod_capture_ctrl #(.ADDR_BITS(4), .TS_BITS(32)) u_small (
    .clk_312p5mhz(clk), .rst_n(rst_n), .p_in(p_in), .n_in(n_in), .arm(arm), .abort(abort),
    .force_trig(force_trig), .trig_mask(trig_mask), .trig_value(trig_value),
    .pretrig_depth(pre_in[3:0]), .posttrig_depth(post_in[3:0]), .mem_wr_en(s_wr_en),
    .mem_wr_addr(s_wr_addr), .mem_wr_data(s_data), .trig_addr(s_trig_addr),
    .trig_timestamp(s_ts), .busy(s_busy), .done(s_done)
  );

  // Cycles elapsed since reset release, as seen during the current cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts_model <= 32'd0;
    else        ts_model <= ts_model + 32'd1;
  end

  always @(negedge clk) begin
    if (b_wr_en) begin
      b_aq.push_back(int'(b_wr_addr)); b_dq.push_back(b_data); b_tq.push_back(ts_model);
    end
    if (s_wr_en) begin
      s_aq.push_back(int'(s_wr_addr)); s_dq.push_back(s_data); s_tq.push_back(ts_model);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit mmatch(input bit f, input logic [7:0] p, input logic [7:0] m,
                                input logic [7:0] v);
    return f || ((m != 8'h00) && ((p & m) == (v & m)));
  endfunction

  function automatic logic [7:0] pgen(input bit want, input logic [7:0] m, input logic [7:0] v);
    logic [7:0] r;
    r = 8'($urandom);
    if (want) return (r & ~m) | (v & m);
    return (r & ~m) | (~v & m);
  endfunction

  task automatic drive(input bit a, input bit ab, input bit f, input logic [7:0] p,
                       input logic [7:0] m, input logic [7:0] v,
                       input logic [11:0] pr, input logic [11:0] po);
    @(posedge clk);
    #1;
    arm = a; abort = ab; force_trig = f; p_in = p; n_in = 8'($urandom);
    trig_mask = m; trig_value = v; pre_in = pr; post_in = po;
    sp.push_back(p); sn.push_back(n_in); sf.push_back(f);
  endtask

  // Idle cycles carry junk config to show it is ignored outside arm.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive(1'b0, 1'b0, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom),
            12'($urandom), 12'($urandom));
  endtask

  task automatic clear_q();
    sp.delete(); sn.delete(); sf.delete();
    b_aq.delete(); b_dq.delete(); b_tq.delete();
    s_aq.delete(); s_dq.delete(); s_tq.delete();
  endtask

  task automatic check_dut(input string nm, input int aw, input int pre_d, input int post_d,
                           input logic [7:0] m, input logic [7:0] v,
                           input int unsigned aq[$], input logic [15:0] dq[$],
                           input logic [31:0] tq[$], input logic [11:0] tr_addr,
                           input logic [31:0] tr_ts, input logic dn, input logic bsy);
    int t;
    int nexp;
    t = -1;
    for (int k = pre_d; k < sp.size(); k++)
      if (mmatch(sf[k], sp[k], m, v)) begin t = k; break; end
    if (t < 0) begin
      chk({nm, "_trigger_found"}, 64'd0, 64'd1);
      return;
    end
    nexp = t + 1 + post_d;
    chk({nm, "_write_count"}, 64'(aq.size()), 64'(nexp));
    for (int i = 0; i < aq.size() && i < nexp; i++) begin
      chk({nm, "_wr_addr"}, 64'(aq[i]), 64'(i % (1 << aw)));
      chk({nm, "_wr_data"}, 64'(dq[i]), 64'({sn[i], sp[i]}));
    end
    chk({nm, "_trig_addr"}, 64'(tr_addr), 64'(t % (1 << aw)));
`ifdef LOGIC_POD_TRIG_TIMESTAMP_EN
    if (t < tq.size()) chk({nm, "_trig_ts"}, 64'(tr_ts), 64'(tq[t]));
    else               chk({nm, "_trig_ts_write_seen"}, 64'd0, 64'd1);
`else
    chk({nm, "_trig_ts"}, 64'(tr_ts), 64'd0);
`endif
    chk({nm, "_done"}, 64'(dn), 64'd1);
    chk({nm, "_busy_after_done"}, 64'(bsy), 64'd0);
  endtask

  // mode 0: each sample matches with probability 1/4; mode 1: match only at
  // sample hit_a and from sample hit_b on. force_trig is held from force_at on.
  task automatic run_capture(input int pre, input int post, input logic [7:0] m,
                             input logic [7:0] v, input int mode, input int hit_a,
                             input int hit_b, input int force_at, input bit stray);
    int  k;
    bit  a, f, want;
    clear_q();
    k = 0;
    while (1) begin
      a = (k == 0) || (stray && k == 2);
      f = (force_at >= 0 && k >= force_at) || (k >= 200);
      want = (mode == 0) ? ($urandom_range(0, 3) == 0)
                         : ((k == hit_a) || (hit_b >= 0 && k >= hit_b));
      if (k == 0) drive(1'b1, 1'b0, f, pgen(want, m, v), m, v, 12'(pre), 12'(post));
      else        drive(a, 1'b0, f, pgen(want, m, v), 8'($urandom), 8'($urandom),
                        12'($urandom), 12'($urandom));
      k++;
      if (k >= 2 && b_done && s_done) break;
      if (k > 700) begin
        chk("capture_timeout", 64'd0, 64'd1);
        break;
      end
    end
    idle(4);
    check_dut("big", 12, pre, post, m, v, b_aq, b_dq, b_tq, b_trig_addr, b_ts, b_done, b_busy);
    check_dut("small", 4, pre % 16, post % 16, m, v, s_aq, s_dq, s_tq, s_trig_addr, s_ts,
              s_done, s_busy);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] m;
    int pre;
    rst_n = 1'b0; arm = 1'b0; abort = 1'b0; force_trig = 1'b0;
    p_in = 8'h00; n_in = 8'h00; trig_mask = 8'h00; trig_value = 8'h00;
    pre_in = 12'd0; post_in = 12'd0;
    #23;
    chk("rst_wr_en", 64'(b_wr_en), 64'd0);
    chk("rst_wr_addr", 64'(b_wr_addr), 64'd0);
    chk("rst_wr_data", 64'(b_data), 64'd0);
    chk("rst_trig_addr", 64'(b_trig_addr), 64'd0);
    chk("rst_trig_ts", 64'(b_ts), 64'd0);
    chk("rst_busy", 64'(b_busy), 64'd0);
    chk("rst_done", 64'(b_done), 64'd0);
    chk("rst_small_wr_en", 64'(s_wr_en), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    chk("idle_no_write", 64'(b_aq.size()), 64'd0);

    // pre 0 / post 0 / force at arm: one write at address 0
    run_capture(0, 0, 8'h00, 8'h00, 1, -1, -1, 0, 1'b0);
    // pre 16, post 8, bit0 rises 40 samples after arm
    run_capture(16, 8, 8'h01, 8'h01, 1, -1, 40, -1, 1'b0);
    // match at sample 5 inside FILL is ignored, real trigger at 100
    run_capture(32, 4, 8'h01, 8'h01, 1, 5, 100, -1, 1'b0);
    // long wait then force: small instance wraps 15 -> 0
    run_capture(2, 5, 8'h00, 8'h00, 1, -1, -1, 40, 1'b0);

    for (int r = 0; r < 10; r++) begin
      m   = ($urandom_range(0, 3) == 0) ? 8'h00 : (8'h1 << $urandom_range(0, 7));
      pre = $urandom_range(0, 15);
      run_capture(pre, $urandom_range(0, 15), m, 8'($urandom), 0, -1, -1,
                  ($urandom_range(0, 1) == 1) ? $urandom_range(0, 30) : -1,
                  (pre >= 4) && ($urandom_range(0, 1) == 1));
    end

    // abort during POST
    clear_q();
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 12'd3, 12'd10);
    for (int k = 1; k < 6; k++)
      drive(1'b0, 1'b0, (k >= 3), 8'($urandom), 8'($urandom), 8'($urandom),
            12'($urandom), 12'($urandom));
    chk("abort_pre_trig_addr", 64'(b_trig_addr), 64'd3);
    chk("abort_pre_busy", 64'(b_busy), 64'd1);
    drive(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 12'd0, 12'd0);
    idle(1);
    chk("abort_wr_en", 64'(b_wr_en), 64'd0);
    chk("abort_small_wr_en", 64'(s_wr_en), 64'd0);
    chk("abort_busy", 64'(b_busy), 64'd0);
    chk("abort_done", 64'(b_done), 64'd0);
    clear_q();
    idle(8);
    chk("abort_no_writes", 64'(b_aq.size() + s_aq.size()), 64'd0);

    // arm and abort together: abort wins
    drive(1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 12'd0, 12'd0);
    idle(1);
    chk("arm_abort_wr_en", 64'(b_wr_en), 64'd0);
    chk("arm_abort_busy", 64'(b_busy), 64'd0);
    chk("arm_abort_done", 64'(b_done), 64'd0);
    clear_q();
    idle(6);
    chk("arm_abort_no_writes", 64'(b_aq.size() + s_aq.size()), 64'd0);

    // reset while waiting for a trigger
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 12'd2, 12'd3);
    idle(10);
    chk("midrst_busy_before", 64'(b_busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_wr_en", 64'(b_wr_en), 64'd0);
    chk("midrst_wr_addr", 64'(b_wr_addr), 64'd0);
    chk("midrst_wr_data", 64'(b_data), 64'd0);
    chk("midrst_busy", 64'(b_busy), 64'd0);
    chk("midrst_trig_addr", 64'(b_trig_addr), 64'd0);
    chk("midrst_small_wr_en", 64'(s_wr_en), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("postrst_wr_en", 64'(b_wr_en), 64'd0);
    chk("postrst_small_wr_en", 64'(s_wr_en), 64'd0);
    chk("postrst_busy", 64'(b_busy), 64'd0);

    // capture after reset: timestamp counts from the release
    run_capture(3, 2, 8'h80, 8'h80, 1, -1, 12, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
